// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

  // Operand width shared with the tree multiplier (dividend is twice this)
  localparam int DIV_N = 32;

  // Counter must hold the value N itself, hence N+1 codes
  localparam int DIV_CNT_W = $clog2(DIV_N + 1);

  // Quotient reported on divide-by-zero and overflow
  localparam logic [DIV_N-1:0] DIV_ERR_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division iteration
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_rem,
  output logic         o_q
);

  logic [N:0] w_partial;
  logic [N:0] w_trial;

  // The datapath keeps rem < divisor, so partial < 2*divisor and the
  // top bit of the (N+1)-bit difference is a reliable borrow flag.
  assign w_partial = {i_rem, i_bit};
  assign w_trial   = w_partial - {1'b0, i_divisor};
  assign o_q       = ~w_trial[N];
  assign o_rem     = o_q ? w_trial[N-1:0] : w_partial[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, optional signed mode via DIVIDER_SIGNED_EN
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_en,
  input  logic           i_start,
  input  logic [2*N-1:0] i_dividend,
  input  logic [N-1:0]   i_divisor,
  output logic           o_busy,
  output logic           o_done,
  output logic [N-1:0]   o_quotient,
  output logic [N-1:0]   o_remainder,
  output logic           o_overflow,
  output logic           o_div_by_zero
);

  localparam int CW = DIV_CNT_W;

  div_state_e     r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_rem;      // running partial remainder
  logic [N-1:0]   r_lo;       // dividend bits shift out of the top, quotient bits in at the bottom
  logic [N-1:0]   r_divisor;  // divisor magnitude
  logic           r_ovf;
  logic           r_dbz;

  logic [2*N-1:0] w_dvd_mag;
  logic [N-1:0]   w_dsr_mag;
  logic [N-1:0]   w_step_rem;
  logic           w_step_q;
  logic [N-1:0]   w_q_next;
  logic [N-1:0]   w_fin_q;
  logic [N-1:0]   w_fin_r;
  logic           w_fin_ovf;

  div_step #(.N(N)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_lo[N-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  assign w_q_next = {r_lo[N-2:0], w_step_q};

`ifdef DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_q_too_big;

  assign w_dvd_mag   = i_dividend[2*N-1] ? -i_dividend : i_dividend;
  assign w_dsr_mag   = i_divisor[N-1] ? -i_divisor : i_divisor;
  // Negative results may reach 2^(N-1); positive ones stop at 2^(N-1)-1
  assign w_q_too_big = r_neg_q ? (w_q_next > {1'b1, {(N-1){1'b0}}}) : w_q_next[N-1];
  assign w_fin_ovf   = w_q_too_big;
  assign w_fin_q     = w_q_too_big ? DIV_ERR_QUOT : (r_neg_q ? -w_q_next : w_q_next);
  assign w_fin_r     = r_neg_r ? -w_step_rem : w_step_rem;

  // Result signs captured with the operands
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_en && r_state == IDLE && i_start) begin
      r_neg_q <= i_dividend[2*N-1] ^ i_divisor[N-1];
      r_neg_r <= i_dividend[2*N-1];
    end
  end
`else
  assign w_dvd_mag = i_dividend;
  assign w_dsr_mag = i_divisor;
  assign w_fin_q   = w_q_next;
  assign w_fin_r   = w_step_rem;
  assign w_fin_ovf = 1'b0;
`endif

  // FSM plus datapath: operand capture, error short-cut, one quotient bit per enabled cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_lo      <= '0;
      r_divisor <= '0;
      r_ovf     <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
            r_cnt     <= CW'(N);
            r_divisor <= w_dsr_mag;
            if (i_divisor == '0) begin
              r_dbz   <= 1'b1;
              r_lo    <= DIV_ERR_QUOT;
              r_rem   <= i_dividend[N-1:0];
              r_state <= DONE;
            end else if (w_dvd_mag[2*N-1:N] >= w_dsr_mag) begin
              r_ovf   <= 1'b1;
              r_lo    <= DIV_ERR_QUOT;
              r_rem   <= '0;
              r_state <= DONE;
            end else begin
              // Upper half is already below the divisor, so it seeds the remainder
              r_rem   <= w_dvd_mag[2*N-1:N];
              r_lo    <= w_dvd_mag[N-1:0];
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_lo    <= w_fin_q;
            r_rem   <= w_fin_r;
            r_ovf   <= w_fin_ovf;
            r_state <= DONE;
          end else begin
            r_lo  <= w_q_next;
            r_rem <= w_step_rem;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == DONE);
  assign o_quotient    = r_lo;
  assign o_remainder   = r_rem;
  assign o_overflow    = r_ovf;
  assign o_div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider that inverts the team's tree multiplier. It takes a 2N-bit dividend, the multiplier's product width, and an N-bit divisor. It returns an N-bit quotient and an N-bit remainder, with overflow and divide-by-zero flags. One quotient bit resolves per cycle under a start/busy/done handshake. It sits beside the registered multiplier in the arithmetic unit and shares its clock, reset and enable.

## Interface
- N, 32, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  clock enable; when low, all state and outputs hold and start is not sampled
- start  in  1  request; sampled only in IDLE with en=1
- dividend  in  2N  captured on accepted start
- divisor  in  N  captured on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse (state DONE); results valid from then until next accepted start
- quotient  out  N  registered result
- remainder  out  N  registered result
- overflow  out  1  quotient does not fit in N bits
- div_by_zero  out  1  divisor was zero

## Operation
- FSM states: IDLE, RUN, DONE. IDLE -> RUN on accepted start. RUN -> DONE after N iterations. DONE -> IDLE unconditionally. Each transition requires en=1.
- Accepted start registers the operands, clears flags and loads the iteration counter with N.
- Error check at the start edge, with divisor == 0 taking priority:
  - divisor == 0: go straight to DONE; div_by_zero=1, quotient = all ones, remainder = dividend[N-1:0].
  - dividend[2N-1:N] >= divisor: go straight to DONE; overflow=1, quotient = all ones, remainder = 0.
- Iteration in RUN, restoring, unsigned:
  - partial remainder (N+1 bits) = {rem, next dividend bit};
  - trial = partial - divisor;
  - if non-negative, rem = trial and q bit = 1; otherwise rem is kept and q bit = 0;
  - the counter decrements.
- start while busy (RUN or DONE) is ignored, with no queuing. Back-to-back operations therefore need one IDLE cycle.
- Reset asserted mid-operation aborts the operation immediately, and all outputs go to their reset values.
- Reset values: busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, state=IDLE.

## Timing
- Start sampled at edge 0.
- Normal operation: RUN iterations occur on edges 1..N, and DONE is entered at edge N. done is high from edge N to edge N+1, giving a latency of N+1 cycles. busy is high from edge 0 to edge N+1.
- Error cases: DONE is entered at edge 0, so done is high from edge 0 to edge 1, a latency of 1 cycle.
- Each cycle with en=0 extends the latency by exactly one cycle. A done pulse with en held low stays high until the next enabled edge.
- Outputs are registered only, with no combinational path from any input to any output.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - dividend and divisor are two's complement; iterations run on magnitudes.
  - Signs are applied on the edge that enters DONE, so latency is unchanged. The quotient truncates toward zero and the remainder takes the dividend's sign.
  - The overflow check uses magnitudes at start. It also sets overflow at the end of RUN if the magnitude quotient exceeds 2^(N-1)-1 for a positive result or 2^(N-1) for a negative result.
  - In error cases the quotient is still all ones.
- Undefined: unsigned operation only; no sign logic is synthesized.

## Structure
- Package div_pkg:
  - state enum (IDLE, RUN, DONE);
  - counter width constant $clog2(N+1);
  - error quotient constant (all ones).
- Sub-module div_step: combinational single restoring iteration. Inputs are rem, the dividend bit and the divisor. Outputs are the new rem and the q bit. It is instantiated once in the datapath.

## Test plan
- N=32, dividend=100, divisor=7, start pulse -> done 33 cycles after start edge; quotient=14, remainder=2, flags 0.
- dividend=64'h0000_0001_0000_0000, divisor=2 -> quotient=32'h8000_0000, remainder=0, overflow=0.
- dividend={32'h5,32'h0}, divisor=5 -> done after 1 cycle; overflow=1, quotient=32'hFFFF_FFFF, remainder=0.
- divisor=0, dividend=64'h1234 -> done after 1 cycle; div_by_zero=1, quotient=all ones, remainder=32'h1234.
- Start 100/7, drop en for 3 cycles mid-RUN, pulse start again during RUN -> done 36 cycles after start with 14 r 2; second start ignored.
- Assert reset at iteration 10 -> all outputs 0 and busy=0 immediately; a new start after release gives correct results. With DIVIDER_SIGNED_EN: -100/7 -> quotient=-14, remainder=-2.
